addsub_seq: RTL



---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_chunk.sv | 16 +
 rtl/addsub_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared state encoding and mode constants for the sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit full adder slice, reused every RUN cycle by addsub_seq.
module addsub_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: WIDTH bits, CHUNK bits per clock through one chunk adder.
// Optional saturation of overflowing results is enabled with macro ADDSUB_SAT_EN.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] x_c, y_c, s_c;
  logic             co_c, last_c, ovf_c;
  logic [WIDTH-1:0] sum_nx;

`ifdef ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_value(input logic a_msb);
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (x_c),
    .y  (y_c),
    .ci (carry_q),
    .s  (s_c),
    .co (co_c)
  );

  // b_q already holds ~b for subtract, so one overflow rule covers both modes
  always_comb begin
    x_c    = a_q[idx_q*CHUNK +: CHUNK];
    y_c    = b_q[idx_q*CHUNK +: CHUNK];
    sum_nx = sum_q;
    sum_nx[idx_q*CHUNK +: CHUNK] = s_c;
    last_c = (idx_q == IDX_W'(N - 1));
    ovf_c  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = (mode == MODE_SUB) ? ~b : b;
          carry_d = (mode == MODE_SUB) ? ~cin : cin;
          mode_d  = mode;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_nx;
        carry_d = co_c;
        if (last_c) begin
          idx_d    = '0;
          result_d = sum_nx;
`ifdef ADDSUB_SAT_EN
          if (ovf_c) result_d = sat_value(a_q[WIDTH-1]);
`endif
          cout_d   = (mode_q == MODE_SUB) ? ~co_c : co_c;
          ovf_d    = ovf_c;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand and partial-sum storage carries no reset; it is reloaded on every capture
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    sum_q   <= sum_d;
    carry_q <= carry_d;
    mode_q  <= mode_d;
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
